fetch_stage: RTL and testbench

- Instruction-fetch stage for the pipelined LEGv8 CPU; sits directly upstream of the decode/register-read logic in cpu_top.
- Owns the program counter and drives the instruction-memory address.
- Captures each fetched word into the IF/ID pipeline register.
- Handles stall, branch redirect/flush, and detection of the terminating self-loop (B #0) that the CPU benches use as end-of-program.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect handling and B #0 halt detection.
// Optional FETCH_STATS_EN adds saturating fetch/bubble counters.
module fetch_stage #(
    parameter logic [63:0] RESET_PC     = 64'd0,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR   = 32'h1400_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misaligned
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [63:0] pc;

    assign imem_addr = pc;
    assign halted    = (state == HALTED);

`ifdef FETCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_pc    <= 64'd0;
            if_id_instr <= BUBBLE_INSTR;
            if_id_valid <= 1'b0;
            misaligned  <= 1'b0;
            state       <= RUN;
`ifdef FETCH_STATS_EN
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
`endif
        end else if (redirect) begin
            // Redirect beats stall and is the only way out of HALTED.
            pc          <= {redirect_pc[63:2], 2'b00};
            if_id_instr <= BUBBLE_INSTR;
            if_id_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00)
                misaligned <= 1'b1;
            state       <= RUN;
`ifdef FETCH_STATS_EN
            bubble_count <= sat_inc(bubble_count);
`endif
        end else if (!stall) begin
            if (state == RUN) begin
                if_id_pc    <= pc;
                if_id_instr <= imem_instr;
                if_id_valid <= 1'b1;
                // The halt word is latched but the PC parks on it.
                if (imem_instr == HALT_INSTR)
                    state <= HALTED;
                else
                    pc <= pc + 64'd4;
`ifdef FETCH_STATS_EN
                fetch_count <= sat_inc(fetch_count);
`endif
            end else begin
                if_id_instr <= BUBBLE_INSTR;
                if_id_valid <= 1'b0;
`ifdef FETCH_STATS_EN
                bubble_count <= sat_inc(bubble_count);
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid, halted, misaligned;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, bubble_count;
`endif

    logic        halt_en;
    logic [63:0] halt_at;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [31:0] NOP  = 32'h9100_0421;
    localparam logic [31:0] HALT = 32'h1400_0000;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .halted(halted), .misaligned(misaligned)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_instr = NOP;
        if (halt_en && imem_addr == halt_at)
            imem_instr = HALT;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
        halt_en = 1'b0; halt_at = 64'd0;
        step(); step();
        chk("rst_pc", imem_addr, 64'd0);
        chk("rst_ifid_pc", if_id_pc, 64'd0);
        chk("rst_instr", {32'd0, if_id_instr}, 64'd0);
        chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_misal", {63'd0, misaligned}, 64'd0);

        // Sequential fetch
        reset = 1'b0;
        step(); step(); step();
        chk("seq_pc", imem_addr, 64'd12);
        chk("seq_ifid_pc", if_id_pc, 64'd8);
        chk("seq_valid", {63'd0, if_id_valid}, 64'd1);
        chk("seq_instr", {32'd0, if_id_instr}, {32'd0, NOP});

        // Stall hold at PC=16
        step();
        chk("pre_stall_pc", imem_addr, 64'd16);
        stall = 1'b1;
        step(); step();
        chk("stall_pc", imem_addr, 64'd16);
        chk("stall_ifid_pc", if_id_pc, 64'd12);
        chk("stall_valid", {63'd0, if_id_valid}, 64'd1);
        chk("stall_instr", {32'd0, if_id_instr}, {32'd0, NOP});
        stall = 1'b0;
        step();
        chk("resume_ifid_pc", if_id_pc, 64'd16);
        chk("resume_pc", imem_addr, 64'd20);

        // Redirect with simultaneous stall
        redirect = 1'b1; redirect_pc = 64'd100; stall = 1'b1;
        step();
        chk("redir_pc", imem_addr, 64'd100);
        chk("redir_valid", {63'd0, if_id_valid}, 64'd0);
        chk("redir_instr", {32'd0, if_id_instr}, 64'd0);
        chk("redir_misal", {63'd0, misaligned}, 64'd0);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("redir_ifid_pc", if_id_pc, 64'd100);
        chk("redir_ifid_valid", {63'd0, if_id_valid}, 64'd1);
        chk("redir_next_pc", imem_addr, 64'd104);

        // Halt at PC=40
        redirect = 1'b1; redirect_pc = 64'd40;
        step();
        redirect = 1'b0; halt_en = 1'b1; halt_at = 64'd40;
        step();
        chk("halt_ifid_pc", if_id_pc, 64'd40);
        chk("halt_instr", {32'd0, if_id_instr}, {32'd0, HALT});
        chk("halt_valid", {63'd0, if_id_valid}, 64'd1);
        chk("halt_pc", imem_addr, 64'd40);
        chk("halt_flag", {63'd0, halted}, 64'd1);
        step();
        chk("drain_valid", {63'd0, if_id_valid}, 64'd0);
        chk("drain_instr", {32'd0, if_id_instr}, 64'd0);
        for (int i = 0; i < 10; i++) step();
        chk("halt_hold_pc", imem_addr, 64'd40);
        chk("halt_hold_flag", {63'd0, halted}, 64'd1);

        // Halt exit via misaligned redirect
        redirect = 1'b1; redirect_pc = 64'h66;
        step();
        chk("exit_pc", imem_addr, 64'h64);
        chk("exit_halted", {63'd0, halted}, 64'd0);
        chk("exit_misal", {63'd0, misaligned}, 64'd1);
        chk("exit_valid", {63'd0, if_id_valid}, 64'd0);
        redirect = 1'b0; halt_en = 1'b0;
        step();
        chk("exit_ifid_pc", if_id_pc, 64'h64);
        chk("exit_ifid_valid", {63'd0, if_id_valid}, 64'd1);
        chk("misal_sticky", {63'd0, misaligned}, 64'd1);

        // Reset while stalled at PC=200
        redirect = 1'b1; redirect_pc = 64'd200;
        step();
        redirect = 1'b0;
        chk("pre_rst_pc", imem_addr, 64'd200);
        chk("pre_rst_misal", {63'd0, misaligned}, 64'd1);
        stall = 1'b1; reset = 1'b1;
        step();
        chk("rst2_pc", imem_addr, 64'd0);
        chk("rst2_valid", {63'd0, if_id_valid}, 64'd0);
        chk("rst2_misal", {63'd0, misaligned}, 64'd0);
        chk("rst2_halted", {63'd0, halted}, 64'd0);
        chk("rst2_ifid_pc", if_id_pc, 64'd0);
        reset = 1'b0; stall = 1'b0;
        step();
        chk("post_rst_ifid_pc", if_id_pc, 64'd0);
        chk("post_rst_valid", {63'd0, if_id_valid}, 64'd1);
        chk("post_rst_pc", imem_addr, 64'd4);

        // PC wrap
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap_pre_pc", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc", imem_addr, 64'd0);
        chk("wrap_ifid_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
`ifdef FETCH_STATS_EN
        chk("stat_fetch", {32'd0, fetch_count}, 64'd2);
        chk("stat_bubble", {32'd0, bubble_count}, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
